// File: rtl/io_rle_if.sv
// Field/flush/word handshake bundle between the read sequencer, the RLE encoder and the host bus.
interface io_rle_if #(
   parameter int FIELD_W = 16,
   parameter int WORD_W  = 32,
   parameter int LEN_W   = 5
);
   logic               field_valid;
   logic               field_ready;
   logic [FIELD_W-1:0] field_data;
   logic [LEN_W-1:0]   field_len;
   logic               flush;
   logic               flush_done;
   logic [WORD_W-1:0]  word_data;
   logic               word_valid;
   logic               word_ack;

   modport master (
      output field_valid, field_data, field_len, flush, word_ack,
      input  field_ready, flush_done, word_data, word_valid
   );

   modport slave (
      input  field_valid, field_data, field_len, flush, word_ack,
      output field_ready, flush_done, word_data, word_valid
   );
endinterface

// File: rtl/io_rle_encoder.sv
// RLE encoder: L-bit field takes 1 accept + L shift cycles; SHIFT stalls only when a word completes into a full output.
// Optional IO_RLE_WORD_COUNT_EN adds a 16-bit count of words entering the output register.
module io_rle_encoder #(
   parameter int FIELD_W = 16,
   parameter int RUN_W   = 3,
   parameter int WORD_W  = 32
) (
   input  logic        clk,
   input  logic        rst,
   io_rle_if.slave     bus
`ifdef IO_RLE_WORD_COUNT_EN
   ,
   output logic [15:0] word_count
`endif
);
   localparam int NIB_W   = RUN_W + 1;
   localparam int NIBBLES = WORD_W / NIB_W;
   localparam int NC_W    = $clog2(NIBBLES);
   localparam int LEN_W   = $clog2(FIELD_W + 1);
   localparam int SH_W    = $clog2(WORD_W);
   localparam logic [RUN_W-1:0] MAX_RUN       = '1;
   localparam logic [NC_W-1:0]  LAST_NIB      = NC_W'(NIBBLES - 1);
   localparam logic [LEN_W-1:0] FIELD_LEN_MAX = LEN_W'(FIELD_W);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH} state_t;

   state_t             state_q, state_d;
   logic [FIELD_W-1:0] sh_q, sh_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               run_bit_q, run_bit_d;
   logic [RUN_W-1:0]   run_len_q, run_len_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic [NC_W-1:0]    nib_cnt_q, nib_cnt_d;
   logic [WORD_W-1:0]  out_q, out_d;
   logic               out_vld_q, out_vld_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;

   logic               cur_bit, emit, out_free, xfer;
   logic [NIB_W-1:0]   nib;
   logic [SH_W-1:0]    nib_sh;
   logic [WORD_W-1:0]  nib_pos;
   logic [LEN_W-1:0]   len_clamp;

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      run_bit_d = run_bit_q;
      run_len_d = run_len_q;
      pack_d    = pack_q;
      nib_cnt_d = nib_cnt_q;
      out_d     = out_q;
      done_d    = 1'b0;
      xfer      = 1'b0;

      cur_bit   = sh_q[FIELD_W-1];
      emit      = (run_len_q != '0) && ((cur_bit != run_bit_q) || (run_len_q == MAX_RUN));
      nib       = {run_bit_q, run_len_q};
      nib_sh    = SH_W'(nib_cnt_q) * SH_W'(NIB_W);
      nib_pos   = {nib, {(WORD_W-NIB_W){1'b0}}} >> nib_sh;
      out_free  = !out_vld_q || bus.word_ack;
      len_clamp = (bus.field_len > FIELD_LEN_MAX) ? FIELD_LEN_MAX : bus.field_len;

      case (state_q)
         S_IDLE: begin
            if (bus.field_valid && ready_q) begin
               if (len_clamp != '0) begin
                  sh_d    = bus.field_data << (FIELD_LEN_MAX - len_clamp);
                  cnt_d   = len_clamp;
                  state_d = S_SHIFT;
               end
            // done_q guard stops a still-high flush from re-triggering in its done cycle
            end else if (bus.flush && !done_q) begin
               state_d = S_FLUSH;
            end
         end
         S_SHIFT: begin
            if (!(emit && (nib_cnt_q == LAST_NIB) && !out_free)) begin
               if (emit) begin
                  if (nib_cnt_q == LAST_NIB) begin
                     out_d     = pack_q | nib_pos;
                     xfer      = 1'b1;
                     pack_d    = '0;
                     nib_cnt_d = '0;
                  end else begin
                     pack_d    = pack_q | nib_pos;
                     nib_cnt_d = nib_cnt_q + NC_W'(1);
                  end
               end
               if (emit || (run_len_q == '0)) begin
                  run_bit_d = cur_bit;
                  run_len_d = RUN_W'(1);
               end else begin
                  run_len_d = run_len_q + RUN_W'(1);
               end
               sh_d  = sh_q << 1;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            // Pack never holds a full word, so pending run plus pack always fits one word
            if ((run_len_q == '0) && (nib_cnt_q == '0)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (out_free) begin
               out_d     = pack_q | ((run_len_q != '0) ? nib_pos : '0);
               xfer      = 1'b1;
               pack_d    = '0;
               nib_cnt_d = '0;
               run_bit_d = 1'b0;
               run_len_d = '0;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      out_vld_d = xfer || (out_vld_q && !bus.word_ack);
      ready_d   = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         run_bit_q <= 1'b0;
         run_len_q <= '0;
         pack_q    <= '0;
         nib_cnt_q <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         run_bit_q <= run_bit_d;
         run_len_q <= run_len_d;
         pack_q    <= pack_d;
         nib_cnt_q <= nib_cnt_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.field_ready = ready_q;
   assign bus.flush_done  = done_q;
   assign bus.word_data   = out_q;
   assign bus.word_valid  = out_vld_q;

`ifdef IO_RLE_WORD_COUNT_EN
   logic [15:0] wc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      wc_q <= '0;
      else if (xfer) wc_q <= wc_q + 16'd1;
   end

   assign word_count = wc_q;
`endif
endmodule

// File: tb/tb_io_rle_encoder.sv
// Bench for io_rle_encoder: directed scenarios plus randomized fields/acks against a bit-stream run model.
module tb_io_rle_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   hold_ack = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   total_got = 0;

   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] mdl_q[$];
   logic [31:0] all_q[$];
   bit          seg_bits[$];

   io_rle_if #(.FIELD_W(16), .WORD_W(32), .LEN_W(5)) bus ();

`ifdef IO_RLE_WORD_COUNT_EN
   logic [15:0] word_count;
`endif

   io_rle_encoder #(.FIELD_W(16), .RUN_W(3), .WORD_W(32)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
`ifdef IO_RLE_WORD_COUNT_EN
      ,
      .word_count (word_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t exceeded, required completion", $time);
      $fatal(1);
   end

   // Host side: random ack; a word is consumed when ack is high with word_valid at the next edge
   initial begin
      bus.word_ack = 1'b0;
      forever begin
         @(negedge clk);
         bus.word_ack = (rst_n && !hold_ack) ? ($urandom_range(0, 3) != 0) : 1'b0;
         if (bus.word_ack && bus.word_valid) begin
            got_q.push_back(bus.word_data);
            total_got++;
         end
      end
   end

   // Group the segment's bit stream into runs (max 7), pack 8 nibbles per word MSB-first.
   function automatic void model_words(input bit fl);
      logic [3:0] nibs[$];
      int         rl;
      bit         rb;
      logic [31:0] w;
      mdl_q.delete();
      rl = 0;
      rb = 1'b0;
      foreach (seg_bits[i]) begin
         if (rl != 0 && (seg_bits[i] != rb || rl == 7)) begin
            nibs.push_back({rb, rl[2:0]});
            rl = 0;
         end
         if (rl == 0) rb = seg_bits[i];
         rl++;
      end
      if (fl && rl != 0) nibs.push_back({rb, rl[2:0]});
      if (fl) while (nibs.size() % 8 != 0) nibs.push_back(4'h0);
      for (int k = 0; k + 8 <= nibs.size(); k += 8) begin
         w = '0;
         for (int j = 0; j < 8; j++) w = {w[27:0], nibs[k+j]};
         mdl_q.push_back(w);
      end
   endfunction

   function automatic void model_expect();
      all_q = exp_q;
      model_words(1'b0);
      foreach (mdl_q[i]) all_q.push_back(mdl_q[i]);
   endfunction

   task automatic clear_scenario();
      got_q.delete();
      exp_q.delete();
      seg_bits.delete();
   endtask

   task automatic send_field(input logic [15:0] d, input int len);
      int l;
      int t;
      l = (len > 16) ? 16 : len;
      @(negedge clk);
      bus.field_valid = 1'b1;
      bus.field_data  = d;
      bus.field_len   = 5'(len);
      t = 0;
      while (bus.field_ready !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_checks++;
         n_errors++;
         $display("FAIL field_accept: field_ready=%b after %0d cycles, required 1", bus.field_ready, t);
      end
      @(negedge clk);
      bus.field_valid = 1'b0;
      for (int i = l - 1; i >= 0; i--) seg_bits.push_back(d[i]);
   endtask

   task automatic do_flush(output logic [31:0] done_word, output bit done_vld);
      int t;
      @(negedge clk);
      bus.flush = 1'b1;
      t = 0;
      while (bus.flush_done !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_checks++;
         n_errors++;
         $display("FAIL flush_done_timeout: flush_done=%b after %0d cycles, required 1", bus.flush_done, t);
      end
      done_word = bus.word_data;
      done_vld  = bus.word_valid;
      bus.flush = 1'b0;
      model_words(1'b1);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      seg_bits.delete();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (!(bus.field_ready === 1'b1 && bus.word_valid === 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: ready=%b word_valid=%b, required 1/0", bus.field_ready, bus.word_valid);
      end
   endtask

   task automatic test_reset();
      hold_ack = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.word_valid !== 1'b0 || bus.field_ready !== 1'b0 || bus.flush_done !== 1'b0 || bus.word_data !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: vld=%b rdy=%b done=%b data=%h, required all 0",
                  bus.word_valid, bus.field_ready, bus.flush_done, bus.word_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.field_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready: field_ready=%b, required 1", bus.field_ready);
      end
      send_field(16'hAAAA, 16);
      repeat (12) @(negedge clk);
      n_checks++;
      if (bus.word_valid !== 1'b1 || bus.field_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL midshift_state: word_valid=%b field_ready=%b, required 1/0", bus.word_valid, bus.field_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.word_valid !== 1'b0 || bus.flush_done !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: word_valid=%b flush_done=%b, required 0/0", bus.word_valid, bus.flush_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.field_ready !== 1'b1 || bus.word_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset: field_ready=%b word_valid=%b, required 1/0", bus.field_ready, bus.word_valid);
      end
      clear_scenario();
      total_got = 0;
      hold_ack = 1'b0;
   endtask

   task automatic test_flush_empty();
      int  cyc;
      bit  saw_vld;
      clear_scenario();
      @(negedge clk);
      bus.flush = 1'b1;
      cyc = 0;
      saw_vld = 1'b0;
      while (bus.flush_done !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (bus.word_valid) saw_vld = 1'b1;
      end
      bus.flush = 1'b0;
      n_checks++;
      if (cyc !== 2) begin
         n_errors++;
         $display("FAIL empty_flush_latency: done after %0d cycles, required 2", cyc);
      end
      repeat (4) begin
         @(negedge clk);
         if (bus.word_valid) saw_vld = 1'b1;
      end
      n_checks++;
      if (saw_vld !== 1'b0 || got_q.size() !== 0) begin
         n_errors++;
         $display("FAIL empty_flush_word: word_valid seen=%b words=%0d, required 0/0", saw_vld, got_q.size());
      end
   endtask

   task automatic test_ones();
      logic [31:0] w;
      bit          v;
      clear_scenario();
      send_field(16'hFFFF, 16);
      do_flush(w, v);
      n_checks++;
      if (v !== 1'b1 || w !== 32'hFFA0_0000) begin
         n_errors++;
         $display("FAIL ones_flush_word: valid=%b data=%h, required 1/ffa00000", v, w);
      end
      drain();
      model_expect();
      n_checks++;
      if (got_q.size() !== 1 || all_q.size() !== 1) begin
         n_errors++;
         $display("FAIL ones_count: got %0d model %0d words, required 1", got_q.size(), all_q.size());
      end
   endtask

   task automatic test_alternating();
      logic [31:0] w;
      bit          v;
      clear_scenario();
      send_field(16'hAAAA, 16);
      drain();
      n_checks++;
      if (got_q.size() !== 1) begin
         n_errors++;
         $display("FAIL alt_first_count: got %0d words, required 1", got_q.size());
      end else if (got_q[0] !== 32'h9191_9191) begin
         n_errors++;
         $display("FAIL alt_first_word: got %h, required 91919191", got_q[0]);
      end
      send_field(16'hAAAA, 16);
      drain();
      do_flush(w, v);
      drain();
      model_expect();
      n_checks++;
      if (got_q.size() !== all_q.size()) begin
         n_errors++;
         $display("FAIL alt_count: got %0d words, required %0d", got_q.size(), all_q.size());
      end
      for (int i = 0; i < got_q.size() && i < all_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== all_q[i]) begin
            n_errors++;
            $display("FAIL alt_word[%0d]: got %h, required %h", i, got_q[i], all_q[i]);
         end
      end
   endtask

   task automatic test_span();
      logic [31:0] w;
      bit          v;
      clear_scenario();
      send_field(16'h0000, 4);
      send_field(16'h0000, 4);
      do_flush(w, v);
      drain();
      n_checks++;
      if (got_q.size() !== 1) begin
         n_errors++;
         $display("FAIL span_count: got %0d words, required 1", got_q.size());
      end else if (got_q[0] !== 32'h7100_0000) begin
         n_errors++;
         $display("FAIL span_word: got %h, required 71000000", got_q[0]);
      end
   endtask

   task automatic test_stall();
      logic [31:0] w;
      bit          v;
      clear_scenario();
      hold_ack = 1'b1;
      send_field(16'hAAAA, 16);
      send_field(16'hAAAA, 16);
      repeat (20) @(negedge clk);
      n_checks++;
      if (bus.field_ready !== 1'b0 || bus.word_valid !== 1'b1 || bus.word_data !== 32'h9191_9191) begin
         n_errors++;
         $display("FAIL stall_state: ready=%b valid=%b data=%h, required 0/1/91919191",
                  bus.field_ready, bus.word_valid, bus.word_data);
      end
      hold_ack = 1'b0;
      send_field(16'hAAAA, 16);
      do_flush(w, v);
      drain();
      model_expect();
      n_checks++;
      if (got_q.size() !== all_q.size()) begin
         n_errors++;
         $display("FAIL stall_count: got %0d words, required %0d", got_q.size(), all_q.size());
      end
      for (int i = 0; i < got_q.size() && i < all_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== all_q[i]) begin
            n_errors++;
            $display("FAIL stall_word[%0d]: got %h, required %h", i, got_q[i], all_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      bit          v;
      logic [15:0] d;
      clear_scenario();
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0:       d = 16'($urandom);
            1:       d = 16'hFFFF;
            2:       d = 16'h0000;
            default: d = 16'($urandom) & 16'($urandom);
         endcase
         send_field(d, $urandom_range(0, 20));
         if ($urandom_range(0, 4) == 0) do_flush(w, v);
      end
      do_flush(w, v);
      drain();
      model_expect();
      n_checks++;
      if (got_q.size() !== all_q.size()) begin
         n_errors++;
         $display("FAIL random_count: got %0d words, required %0d", got_q.size(), all_q.size());
      end
      for (int i = 0; i < got_q.size() && i < all_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== all_q[i]) begin
            n_errors++;
            $display("FAIL random_word[%0d]: got %h, required %h", i, got_q[i], all_q[i]);
         end
      end
   endtask

   task automatic test_word_count();
`ifdef IO_RLE_WORD_COUNT_EN
      n_checks++;
      if (word_count !== 16'(total_got)) begin
         n_errors++;
         $display("FAIL word_count: got %0d, required %0d", word_count, total_got);
      end
`endif
   endtask

   initial begin
      bus.field_valid = 1'b0;
      bus.field_data  = '0;
      bus.field_len   = '0;
      bus.flush       = 1'b0;
      test_reset();
      test_flush_empty();
      test_ones();
      test_alternating();
      test_span();
      test_stall();
      test_random();
      test_word_count();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
